// File: rtl/irq_sched.sv
// rtl/irq_sched.sv - interrupt controller/scheduler between interrupt sources and the CPU
//
// Purpose:
//   Latches rising edges of NSRC level interrupt lines into pending bits,
//   masks them, raises a single IRQ to the CPU, selects the highest-priority
//   (lowest index) eligible source on Ack and keeps it in service until
//   software writes EOI.
//
// Optional feature macro: IRQC_TIMEOUT_EN
//   Defined   : service watchdog; a source left in service for TIMEOUT cycles
//               without EOI is dropped and a sticky error (CAUSE bit30) is set.
//               Any write to CAUSE clears the error.
//   Undefined : SERVE waits indefinitely, CAUSE bit30 reads 0, CAUSE writes
//               are ignored.
//
// Ports:
//   Clk    in   1     system clock
//   Reset  in   1     asynchronous active-low reset
//   Addr   in   30    word address [31:2]; only Addr[3:2] decoded
//   WE     in   1     register write strobe
//   Din    in   32    write data
//   Dout   out  32    read data, combinational from Addr[3:2]
//   Src    in   NSRC  level interrupt lines
//   Ack    in   1     CPU has taken the interrupt exception (one-cycle pulse)
//   IRQ    out  1     interrupt request to the CPU
//
// Register map (Addr[3:2]):
//   0 MASK  RW   [NSRC-1:0], 1 = enabled
//   1 PEND  R/W1C
//   2 CAUSE RO   bit31 in-service valid, bit30 timeout error, [2:0] id
//   3 EOI   WO   any write ends service; reads 0

module irq_sched #(
   parameter int NSRC    = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [31:2]     Addr,
   input  logic            WE,
   input  logic [31:0]     Din,
   output logic [31:0]     Dout,
   input  logic [NSRC-1:0] Src,
   input  logic            Ack,
   output logic            IRQ
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_SERVE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nx;

   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] pend;
   logic [NSRC-1:0] pend_nx;
   logic [NSRC-1:0] src_q;
   logic [NSRC-1:0] src_edge;
   logic [NSRC-1:0] eligible;
   logic [NSRC-1:0] take_clr;
   logic [NSRC-1:0] w1c_clr;
   logic [2:0]      id;
   logic [2:0]      winner;
   logic            any_eligible;
   logic            valid;
   logic            error;
   logic            take;
   logic            timeout_hit;

   logic [1:0]      sel;
   logic            wr_mask;
   logic            wr_pend;
   logic            wr_cause;
   logic            wr_eoi;

   // Upper address bits and Din bits beyond the source count are don't-care.
   logic            unused_bits;
   assign unused_bits = ^{Addr[31:4], Din[31:NSRC], wr_cause};

   assign sel      = Addr[3:2];
   assign wr_mask  = WE && (sel == 2'd0);
   assign wr_pend  = WE && (sel == 2'd1);
   assign wr_cause = WE && (sel == 2'd2);
   assign wr_eoi   = WE && (sel == 2'd3);

   assign src_edge     = Src & ~src_q;
   assign eligible     = pend & mask;
   assign any_eligible = |eligible;

   // Lowest-index eligible source wins; scanning downward lets the lowest
   // set bit overwrite any higher one.
   always_comb begin
      winner = 3'd0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner = 3'(i);
         end
      end
   end

`ifdef IRQC_TIMEOUT_EN
   logic [31:0] svc_cnt;
   logic        wd_expired;
   assign wd_expired = (svc_cnt == 32'(TIMEOUT - 1));
`else
   logic        wd_expired;
   assign wd_expired = 1'b0;
`endif

   // Next-state and IRQ decode. IRQ comes purely from the state register so
   // it cannot glitch with bus or source activity.
   always_comb begin
      state_nx    = state;
      take        = 1'b0;
      timeout_hit = 1'b0;
      IRQ         = 1'b0;
      case (state)
         S_IDLE: begin
            if (any_eligible) begin
               state_nx = S_REQ;
            end
         end
         S_REQ: begin
            IRQ = 1'b1;
            if (Ack && any_eligible) begin
               take     = 1'b1;
               state_nx = S_SERVE;
            end else if (!any_eligible) begin
               state_nx = S_IDLE;
            end
         end
         S_SERVE: begin
            // EOI takes precedence over a watchdog expiring in the same cycle.
            if (wr_eoi) begin
               state_nx = S_IDLE;
            end else if (wd_expired) begin
               timeout_hit = 1'b1;
               state_nx    = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Clears (W1C and Ack of the winner) are applied first and the new edges
   // OR-ed in last, so a fresh edge always survives a same-cycle clear.
   assign w1c_clr  = wr_pend ? Din[NSRC-1:0] : '0;
   assign take_clr = take ? (NSRC'(1) << winner) : '0;
   assign pend_nx  = (pend & ~w1c_clr & ~take_clr) | src_edge;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= S_IDLE;
         mask  <= '0;
         pend  <= '0;
         src_q <= '0;
         id    <= 3'd0;
         valid <= 1'b0;
      end else begin
         state <= state_nx;
         pend  <= pend_nx;
         src_q <= Src;
         if (wr_mask) begin
            mask <= Din[NSRC-1:0];
         end
         if (take) begin
            id <= winner;
         end
         // valid tracks residency in SERVE; id is left stale after EOI.
         valid <= (state_nx == S_SERVE);
      end
   end

`ifdef IRQC_TIMEOUT_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         svc_cnt <= 32'd0;
         error   <= 1'b0;
      end else begin
         if (take) begin
            svc_cnt <= 32'd0;
         end else if (state == S_SERVE) begin
            svc_cnt <= svc_cnt + 32'd1;
         end
         // A timeout landing in the same cycle as a CAUSE write is kept.
         if (timeout_hit) begin
            error <= 1'b1;
         end else if (wr_cause) begin
            error <= 1'b0;
         end
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = timeout_hit;
   assign error          = 1'b0;
`endif

   always_comb begin
      Dout = 32'd0;
      case (sel)
         2'd0: Dout[NSRC-1:0] = mask;
         2'd1: Dout[NSRC-1:0] = pend;
         2'd2: begin
            Dout[31]  = valid;
            Dout[30]  = error;
            Dout[2:0] = id;
         end
         default: Dout = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_irq_sched.sv
// tb/tb_irq_sched.sv - scoreboard testbench for irq_sched

module tb_irq_sched;

   localparam int NSRC    = 4;
   localparam int TIMEOUT = 16;

   logic        Clk;
   logic        Reset;
   logic [31:2] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic [3:0]  Src;
   logic        Ack;
   logic        IRQ;

   int total = 0;
   int bad   = 0;

   irq_sched #(.NSRC(NSRC), .TIMEOUT(TIMEOUT)) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .Addr (Addr),
      .WE   (WE),
      .Din  (Din),
      .Dout (Dout),
      .Src  (Src),
      .Ack  (Ack),
      .IRQ  (IRQ)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      bit          irq;
      logic [31:0] dout;
      int          step;
   } exp_t;

   exp_t exp_q[$];
   int   step_no = 0;

   // Reference model: booleans for "requesting" and "in service".
   bit [3:0] m_srcq, m_pend, m_mask;
   bit       m_req, m_svc, m_err;
   int       m_id, m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lowest(input bit [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] model_read(input bit [1:0] ad);
      logic [31:0] r;
      r = 32'd0;
      case (ad)
         2'd0: r[3:0] = m_mask;
         2'd1: r[3:0] = m_pend;
         2'd2: begin r[31] = m_svc; r[30] = m_err; r[2:0] = 3'(m_id); end
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   task automatic model_reset();
      m_srcq = 0; m_pend = 0; m_mask = 0;
      m_req = 0; m_svc = 0; m_err = 0; m_id = 0; m_cnt = 0;
   endtask

   task automatic model_step(input bit [3:0] s, input bit a, input bit we,
                             input bit [1:0] ad, input logic [31:0] d);
      bit [3:0] elig, np, nm;
      int       w;
      bit       take, eoi;
      elig = m_pend & m_mask;
      w    = lowest(elig);
      take = m_req && a && (elig != 0);
      eoi  = we && ad == 2'd3 && m_svc;
      np   = m_pend;
      if (we && ad == 2'd1) np = np & ~d[3:0];
      if (take) np[w] = 1'b0;
      np = np | (s & ~m_srcq);
      nm = (we && ad == 2'd0) ? d[3:0] : m_mask;
`ifdef IRQC_TIMEOUT_EN
      if (we && ad == 2'd2) m_err = 0;
`endif
      if (m_svc) begin
         if (eoi) m_svc = 0;
`ifdef IRQC_TIMEOUT_EN
         else if (m_cnt == TIMEOUT - 1) begin m_svc = 0; m_err = 1; end
         else m_cnt++;
`endif
      end else if (m_req) begin
         if (take) begin m_req = 0; m_svc = 1; m_id = w; m_cnt = 0; end
         else if (elig == 0) m_req = 0;
      end else begin
         m_req = (elig != 0);
      end
      m_pend = np;
      m_mask = nm;
      m_srcq = s;
   endtask

   // One bus/source cycle: inputs change at the falling edge, the expected
   // post-edge view is queued for the monitor.
   task automatic drive(input bit [3:0] s, input bit a, input bit we,
                        input bit [1:0] ad, input logic [31:0] d);
      exp_t e;
      @(negedge Clk);
      Reset = 1'b1;
      Src = s; Ack = a; WE = we; Din = d;
      Addr = {28'($urandom), ad};
      model_step(s, a, we, ad, d);
      step_no++;
      e.irq = m_req; e.dout = model_read(ad); e.step = step_no;
      exp_q.push_back(e);
   endtask

   task automatic rd(input bit [3:0] s, input bit [1:0] ad);
      drive(s, 1'b0, 1'b0, ad, 32'd0);
   endtask

   task automatic do_reset();
      exp_t e;
      @(negedge Clk);
      Reset = 1'b0;
      Src = 0; Ack = 0; WE = 0; Din = 0; Addr = {28'd0, 2'd2};
      model_reset();
      #1;
      chk("rst_irq_async", {31'd0, IRQ}, 32'd0);
      chk("rst_cause_async", Dout, 32'd0);
      step_no++;
      e.irq = 0; e.dout = 32'd0; e.step = step_no;
      exp_q.push_back(e);
   endtask

   // Check a register value just after the most recent edge.
   task automatic post_chk(input string name, input logic [31:0] exp);
      @(posedge Clk);
      #2;
      chk(name, Dout, exp);
   endtask

   always @(posedge Clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk($sformatf("irq@%0d", e.step), {31'd0, IRQ}, {31'd0, e.irq});
         chk($sformatf("dout@%0d", e.step), Dout, e.dout);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      bit [3:0] s;
      Reset = 1'b0; Src = 0; Ack = 0; WE = 0; Din = 0; Addr = '0;
      do_reset();

      // Two simultaneous edges, priority, EOI, next winner.
      drive(4'b0000, 0, 1, 2'd0, 32'hFFFF_FFFF);
      rd(4'b1010, 2'd1);
      rd(4'b1010, 2'd2);
      drive(4'b1010, 1, 0, 2'd2, 0);
      post_chk("cause_after_ack", 32'h8000_0001);
      rd(4'b1010, 2'd1);
      drive(4'b1010, 0, 1, 2'd3, 0);
      rd(4'b1010, 2'd2);
      rd(4'b1010, 2'd2);
      drive(4'b1010, 1, 0, 2'd2, 0);
      post_chk("cause_id3", 32'h8000_0003);
      drive(4'b0000, 0, 1, 2'd3, 0);

      // Masked pending, late unmask, mask drop while requesting.
      do_reset();
      rd(4'b0001, 2'd1);
      rd(4'b0001, 2'd1);
      drive(4'b0001, 0, 1, 2'd0, 32'h1);
      rd(4'b0001, 2'd0);
      rd(4'b0001, 2'd0);
      drive(4'b0001, 0, 1, 2'd0, 32'h0);
      rd(4'b0001, 2'd0);

      // Ack while IDLE is ignored; EOI while REQ is ignored.
      drive(4'b0001, 1, 0, 2'd2, 0);
      rd(4'b0001, 2'd2);
      drive(4'b0001, 0, 1, 2'd0, 32'h1);
      rd(4'b0001, 2'd2);
      drive(4'b0001, 0, 1, 2'd3, 0);
      rd(4'b0001, 2'd2);
      drive(4'b0001, 1, 0, 2'd2, 0);
      drive(4'b0001, 0, 1, 2'd3, 0);

      // W1C colliding with a new edge on the same bit: the edge wins.
      drive(4'b0000, 0, 1, 2'd0, 32'h0);
      drive(4'b0000, 0, 1, 2'd1, 32'hF);
      drive(4'b0001, 0, 1, 2'd1, 32'h1);
      post_chk("w1c_vs_edge", 32'h1);
      rd(4'b0001, 2'd1);

      // Reset while id 2 is in service, then a fresh edge afterwards.
      drive(4'b0000, 0, 1, 2'd1, 32'hF);
      drive(4'b0000, 0, 1, 2'd0, 32'hF);
      rd(4'b0100, 2'd2);
      rd(4'b0100, 2'd2);
      drive(4'b0100, 1, 0, 2'd2, 0);
      post_chk("cause_id2", 32'h8000_0002);
      do_reset();
      rd(4'b0000, 2'd1);
      rd(4'b0100, 2'd1);
      rd(4'b0100, 2'd0);

`ifdef IRQC_TIMEOUT_EN
      drive(4'b0000, 0, 1, 2'd0, 32'hF);
      rd(4'b0001, 2'd2);
      rd(4'b0001, 2'd2);
      drive(4'b0001, 1, 0, 2'd2, 0);
      for (int i = 0; i < TIMEOUT; i++) rd(4'b0001, 2'd2);
      post_chk("cause_timeout", 32'h4000_0000);
      drive(4'b0001, 0, 1, 2'd2, 0);
      post_chk("cause_err_clear", 32'h0000_0000);
`else
      drive(4'b0000, 0, 1, 2'd2, 32'hFFFF_FFFF);
      rd(4'b0000, 2'd2);
`endif

      // Randomized traffic against the model.
      s = 0;
      for (int n = 0; n < 3000; n++) begin
         bit a, we;
         bit [1:0] ad;
         for (int b = 0; b < 4; b++) if ($urandom_range(3) == 0) s[b] = ~s[b];
         a  = ($urandom_range(2) == 0);
         we = ($urandom_range(3) == 0);
         ad = 2'($urandom_range(3));
         if ($urandom_range(499) == 0) begin
            do_reset();
            s = 0;
         end else begin
            drive(s, a, we, ad, $urandom);
         end
      end

      @(negedge Clk);
      Ack = 0; WE = 0;
      repeat (3) @(negedge Clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/irq_sched.md
Name: irq_sched

Overview:
- Interrupt controller/scheduler placed between the timer/counter instances (plus external interrupt lines) and the CPU exception logic.
- Latches rising edges from up to NSRC interrupt sources into pending bits and applies a mask.
- Presents a single IRQ to the CPU, picks the highest-priority source on CPU acknowledge, and holds it in service until software writes end-of-interrupt.
- Memory-mapped as a word-addressed bus slave with the same Addr/WE/Din/Dout convention as the timers.

Parameters:
- NSRC, 4, number of interrupt sources (1..8); source 0 has highest priority.
- TIMEOUT, 1024, service watchdog limit in cycles; used only with IRQC_TIMEOUT_EN.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-low reset.
- Addr  input  30  word address [31:2]; only Addr[3:2] decoded.
- WE  input  1  register write strobe.
- Din  input  32  write data.
- Dout  output  32  read data, combinational from Addr[3:2].
- Src  input  NSRC  level interrupt lines (e.g. timer IRQ outputs).
- Ack  input  1  one-cycle pulse: CPU has taken the interrupt exception.
- IRQ  output  1  interrupt request to CPU.

Behaviour:
- Register map (Addr[3:2]):
  - 0 MASK: RW, bits [NSRC-1:0], 1 = enabled.
  - 1 PEND: read pending bits; write-1-to-clear.
  - 2 CAUSE: RO; bit31 = in-service valid, bit30 = timeout error, [2:0] = in-service id.
  - 3 EOI: WO, any write; reads return 0.
- Unused bits read 0.
- Reset (asserted low, async): MASK=0, PEND=0, src_q=0, state=IDLE, id=0, valid=0, error=0. IRQ=0, Dout follows reset registers.
- Edge detect: src_q <= Src every cycle. edge = Src & ~src_q. PEND |= edge at that same clock edge.
- Simultaneous PEND set and clear for one bit (W1C write or Ack clear): set wins.
- eligible = PEND & MASK. winner = lowest-index set bit of eligible.
- State machine (2-bit):
  - IDLE: eligible != 0 -> REQ.
  - REQ: IRQ=1, decoded from state register so it is glitch-free.
    - Ack=1 -> latch id=winner, clear PEND[winner], valid=1, -> SERVE.
    - else if eligible == 0 (masked or cleared) -> IDLE.
    - Ack with eligible==0 in the same cycle -> IDLE, nothing latched.
  - SERVE: IRQ=0, no nesting. Write to EOI -> valid=0, -> IDLE.
- Ack outside REQ is ignored. EOI write outside SERVE is ignored.
- Latency: Src rises before edge k -> PEND set at k -> REQ at k+1 -> IRQ high after k+1. After EOI at edge m, IRQ can reassert after edge m+1 if eligible.
- Register writes and state transitions happen in the same cycle; a write never stalls the state machine.
- MASK write takes effect on eligible the next cycle.
- Source held high produces exactly one pending event until it drops and rises again.
- Only sources [NSRC-1:0] are stored. Din bits above NSRC-1 are ignored.

Optional Feature:
- Macro: IRQC_TIMEOUT_EN.
- Defined:
  - 32-bit counter cleared on entry to SERVE, incremented each SERVE cycle.
  - On reaching TIMEOUT-1 without EOI: force state to IDLE, valid=0, set error (CAUSE bit30).
  - error is sticky; cleared by reset or by writing any value to CAUSE.
  - EOI and timeout in the same cycle: EOI wins, error is not set.
- Not defined: no counter, SERVE waits indefinitely, CAUSE bit30 reads 0, CAUSE writes ignored.

Test Plan:
- Reset low mid-SERVE (id=2) -> IRQ=0 immediately, CAUSE=0, MASK=0, PEND=0; Src held high after release sets PEND only after a new 0->1 transition.
- MASK=4'hF, Src[1] and Src[3] rise in the same cycle -> PEND=4'b1010, IRQ=1 one cycle later; Ack -> CAUSE=32'h8000_0001, PEND=4'b1000, IRQ=0; EOI -> IRQ=1 again; Ack -> CAUSE id=3.
- MASK=0, Src[0] rises -> PEND=1, IRQ stays 0; write MASK=1 -> IRQ=1 two cycles later; in REQ write MASK=0 -> state IDLE, IRQ=0 next cycle.
- W1C write PEND=4'h1 in the same cycle as a new Src[0] edge -> PEND[0] remains 1.
- Ack pulse while IDLE and EOI write while REQ -> no state change, CAUSE unchanged, IRQ unchanged.
- IRQC_TIMEOUT_EN, TIMEOUT=16: Ack, no EOI -> after 16 SERVE cycles CAUSE=32'h4000_0000, IRQ free to reassert; write CAUSE -> bit30=0.
